// File: rtl/my_div_pkg.sv
// Shared definitions for the my_div restoring divider.
//   DivWidth    : operand/result width (only 32 is supported)
//   div_state_e : divider FSM states
package my_div_pkg;

  localparam int unsigned DivWidth = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } div_state_e;

endpackage

// File: rtl/my_sub.sv
// Trial subtractor for the divider: diff_o = minuend_i - subtrahend_i.
//   minuend_i, subtrahend_i : Width-bit unsigned operands
//   diff_o                  : Width-bit difference (modulo 2^Width)
//   nonneg_o                : 1 when minuend_i >= subtrahend_i (no borrow)
module my_sub #(
  parameter int unsigned Width = 33
) (
  input  logic [Width-1:0] minuend_i,
  input  logic [Width-1:0] subtrahend_i,
  output logic [Width-1:0] diff_o,
  output logic             nonneg_o
);

  logic [Width:0] full;

  // The extra top bit captures the borrow.
  assign full     = {1'b0, minuend_i} - {1'b0, subtrahend_i};
  assign diff_o   = full[Width-1:0];
  assign nonneg_o = ~full[Width];

endmodule

// File: rtl/my_div.sv
// Restoring shift-subtract divider, one quotient bit per cycle, MSB first.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request a division (accepted in idle or done)
//   sop        : signed-operation select (only when MY_DIV_SIGNED_EN is defined)
//   a, b       : dividend, divisor
//   q, r       : quotient, remainder (held until the next completion)
//   busy       : high while a division runs
//   done       : one-cycle completion pulse
//   dz         : last result was a divide by zero
// Build option: define MY_DIV_SIGNED_EN to add the sop port and signed division.
module my_div
  import my_div_pkg::*;
#(
  parameter int unsigned WIDTH = DivWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef MY_DIV_SIGNED_EN
  input  logic             sop,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  localparam int unsigned CntW = $clog2(WIDTH);

  div_state_e state_q, state_d;

  // dvd_q shifts the dividend out of its MSB while quotient bits enter at its LSB.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;

  logic             accept;
  logic             run_last;
  logic             b_zero;
  logic             sgn_a, sgn_b;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             nonneg;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

`ifdef MY_DIV_SIGNED_EN
  assign sgn_a = sop & a[WIDTH-1];
  assign sgn_b = sop & b[WIDTH-1];
`else
  assign sgn_a = 1'b0;
  assign sgn_b = 1'b0;
`endif

  assign a_mag  = sgn_a ? (~a + 1'b1) : a;
  assign b_mag  = sgn_b ? (~b + 1'b1) : b;
  assign b_zero = (b == '0);

  assign accept   = start && (state_q != StRun);
  // A zero divisor finishes on the first run cycle.
  assign run_last = zero_q || (cnt_q == CntW'(WIDTH - 1));

  assign shifted = {rem_q, dvd_q[WIDTH-1]};

  my_sub #(
    .Width (WIDTH + 1)
  ) u_sub (
    .minuend_i    (shifted),
    .subtrahend_i ({1'b0, dsr_q}),
    .diff_o       (diff),
    .nonneg_o     (nonneg)
  );

  // When the trial succeeds the difference is below the divisor, so it fits.
  assign rem_next = nonneg ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_next = {dvd_q[WIDTH-2:0], nonneg};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (run_last) state_d = StDone;
      StDone:  state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
    q    = q_q;
    r    = r_q;
    dz   = dz_q;
  end

  // Datapath next-state
  always_comb begin
    dvd_d  = dvd_q;
    dsr_d  = dsr_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    zero_d = zero_q;
    negq_d = negq_q;
    negr_d = negr_q;
    q_d    = q_q;
    r_d    = r_q;
    dz_d   = dz_q;
    if (accept) begin
      // Keep the raw dividend for a zero divisor: it becomes the remainder.
      dvd_d  = b_zero ? a : a_mag;
      dsr_d  = b_mag;
      rem_d  = '0;
      cnt_d  = '0;
      zero_d = b_zero;
      negq_d = sgn_a ^ sgn_b;
      negr_d = sgn_a;
      if (!b_zero) begin
        dz_d = 1'b0;
      end
    end else if (state_q == StRun) begin
      if (zero_q) begin
        q_d  = '1;
        r_d  = dvd_q;
        dz_d = 1'b1;
      end else begin
        dvd_d = quo_next;
        rem_d = rem_next;
        cnt_d = cnt_q + CntW'(1);
        if (run_last) begin
          q_d = negq_q ? (~quo_next + 1'b1) : quo_next;
          r_d = negr_q ? (~rem_next + 1'b1) : rem_next;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q  <= '0;
      dsr_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      zero_q <= 1'b0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      q_q    <= '0;
      r_q    <= '0;
      dz_q   <= 1'b0;
    end else begin
      dvd_q  <= dvd_d;
      dsr_q  <= dsr_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      zero_q <= zero_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      q_q    <= q_d;
      r_q    <= r_d;
      dz_q   <= dz_d;
    end
  end

endmodule
